gray_ptr_rd_ctrl: RTL and testbench

GRAY_PTR_RD_CTRL -- requirements
Module: gray_ptr_rd_ctrl

---
 rtl/gray_ptr_rd_ctrl.sv | 105 ++++++++++
 tb/tb_gray_ptr_rd_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_rd_ctrl.sv
// Read-side controller of an async FIFO: synchronises the Gray write pointer and decodes it to binary.
// Tracks the read pointer and derives occupancy, empty/valid and a sticky overflow flag.
module gray_ptr_rd_ctrl #(
    parameter int width       = 4,
    parameter int speed       = 2,
    parameter int sync_stages = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [width:0]   wptr_gray_i,
    input  logic             rd_req_i,
    output logic             rd_valid_o,
    output logic [width-1:0] rd_addr_o,
    output logic [width:0]   rptr_gray_o,
    output logic [width:0]   level_o,
    output logic             empty_o,
    output logic             overflow_err_o
);

    localparam int n    = width + 1;
    localparam int lvls = $clog2(n);

    localparam logic [width:0] depth_c = {1'b1, {width{1'b0}}};

    // Suffix XOR from the MSB: x[j] holds g[width-j], so the suffix becomes a prefix over x.
    function automatic logic [width:0] gray_to_bin(input logic [width:0] g);
        logic [width:0] x;
        logic [width:0] b;
        for (int j = 0; j < n; j++) x[j] = g[width-j];
        case (speed)
            32'sd2: begin
                for (int k = 0; k < lvls; k++)
                    for (int j = 0; j < n; j++)
                        if ((j >> k) % 2 == 1) x[j] = x[j] ^ x[((j >> k) << k) - 1];
            end
            32'sd1: begin
                for (int k = 0; k < lvls; k++)
                    for (int j = 0; j < n; j++)
                        if ((j + 1) % (2 ** (k + 1)) == 0) x[j] = x[j] ^ x[j - 2 ** k];
                for (int k = lvls - 2; k >= 0; k--)
                    for (int j = 0; j < n; j++)
                        if (((j + 1) % (2 ** (k + 1)) == 2 ** k) && (j >= 2 ** (k + 1)))
                            x[j] = x[j] ^ x[j - 2 ** k];
            end
            default: begin
                for (int j = 1; j < n; j++) x[j] = x[j] ^ x[j-1];
            end
        endcase
        for (int j = 0; j < n; j++) b[width-j] = x[j];
        return b;
    endfunction

    logic [width:0] sync_q [sync_stages];
    logic [width:0] wptr_bin_q, wptr_bin_d;
    logic [width:0] rptr_bin_q, rptr_bin_d;
    logic [width:0] rptr_gray_q, rptr_gray_d;
    logic           overflow_q, overflow_d;
    logic [width:0] level_s;
    logic           empty_s;
    logic           pop_s;

    // Plain flop chain on the asynchronous Gray write pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < sync_stages; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= wptr_gray_i;
            for (int i = 1; i < sync_stages; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Next-state logic; a request while empty leaves the read pointer untouched.
    always_comb begin
        wptr_bin_d  = gray_to_bin(sync_q[sync_stages-1]);
        level_s     = wptr_bin_q - rptr_bin_q;
        empty_s     = (level_s == '0);
        pop_s       = rd_req_i & ~empty_s;
        rptr_bin_d  = rptr_bin_q + {{width{1'b0}}, pop_s};
        rptr_gray_d = rptr_bin_d ^ (rptr_bin_d >> 1);
        overflow_d  = overflow_q | (level_s > depth_c);
    end

    // Pointer and flag registers; reset wins over a concurrent pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_bin_q  <= '0;
            rptr_bin_q  <= '0;
            rptr_gray_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wptr_bin_q  <= wptr_bin_d;
            rptr_bin_q  <= rptr_bin_d;
            rptr_gray_q <= rptr_gray_d;
            overflow_q  <= overflow_d;
        end
    end

    assign level_o        = level_s;
    assign empty_o        = empty_s;
    assign rd_valid_o     = ~empty_s;
    assign rd_addr_o      = rptr_bin_q[width-1:0];
    assign rptr_gray_o    = rptr_gray_q;
    assign overflow_err_o = overflow_q;

endmodule

// File: tb/tb_gray_ptr_rd_ctrl.sv
// Directed bench for gray_ptr_rd_ctrl: three instances (serial, Brent-Kung, Sklansky) share stimulus
// and are compared against hand-computed values.
module tb_gray_ptr_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] wptr_gray;
    logic       rd_req;

    logic       rd_valid  [3];
    logic [3:0] rd_addr   [3];
    logic [4:0] rptr_gray [3];
    logic [4:0] level     [3];
    logic       empty     [3];
    logic       ovf       [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar s = 0; s < 3; s++) begin : g_dut
        gray_ptr_rd_ctrl #(.width(4), .speed(s), .sync_stages(2)) u_dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .wptr_gray_i    (wptr_gray),
            .rd_req_i       (rd_req),
            .rd_valid_o     (rd_valid[s]),
            .rd_addr_o      (rd_addr[s]),
            .rptr_gray_o    (rptr_gray[s]),
            .level_o        (level[s]),
            .empty_o        (empty[s]),
            .overflow_err_o (ovf[s])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input int exp_level, input bit exp_empty,
                               input int exp_addr, input int exp_rgray, input bit exp_ovf);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("%s.s%0d.level", tag, s), 32'(level[s]), 32'(exp_level));
            check($sformatf("%s.s%0d.empty", tag, s), 32'(empty[s]), 32'(exp_empty));
            check($sformatf("%s.s%0d.valid", tag, s), 32'(rd_valid[s]), 32'(!exp_empty));
            check($sformatf("%s.s%0d.addr", tag, s), 32'(rd_addr[s]), 32'(exp_addr));
            check($sformatf("%s.s%0d.rgray", tag, s), 32'(rptr_gray[s]), 32'(exp_rgray));
            check($sformatf("%s.s%0d.ovf", tag, s), 32'(ovf[s]), 32'(exp_ovf));
        end
    endtask

    task automatic tick(input int n_cyc);
        for (int i = 0; i < n_cyc; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [4:0] bin2gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        rst       = 1'b1;
        wptr_gray = 5'b00000;
        rd_req    = 1'b0;
        tick(2);
        rst = 1'b0;
        check_state("reset", 0, 1'b1, 0, 5'b00000, 1'b0);

        // Sync latency: level appears exactly three edges after the change.
        wptr_gray = 5'b00011;
        tick(1);
        check_state("lat_t1", 0, 1'b1, 0, 5'b00000, 1'b0);
        tick(1);
        check_state("lat_t2", 0, 1'b1, 0, 5'b00000, 1'b0);
        tick(1);
        check_state("lat_t3", 2, 1'b0, 0, 5'b00000, 1'b0);

        // Pop twice, third request ignored.
        rd_req = 1'b1;
        tick(1);
        check_state("pop1", 1, 1'b0, 1, 5'b00001, 1'b0);
        tick(1);
        check_state("pop2", 0, 1'b1, 2, 5'b00011, 1'b0);
        tick(1);
        check_state("pop3_ign", 0, 1'b1, 2, 5'b00011, 1'b0);
        rd_req = 1'b0;

        // Walk the read pointer to 31 without exceeding the depth.
        wptr_gray = bin2gray(5'd18);
        tick(3);
        check_state("fill16", 16, 1'b0, 2, 5'b00011, 1'b0);
        rd_req = 1'b1;
        tick(16);
        rd_req = 1'b0;
        check_state("drain16", 0, 1'b1, 2, 5'b11011, 1'b0);
        wptr_gray = bin2gray(5'd31);
        tick(3);
        check_state("fill13", 13, 1'b0, 2, 5'b11011, 1'b0);
        rd_req = 1'b1;
        tick(13);
        rd_req = 1'b0;
        check_state("rptr31", 0, 1'b1, 15, 5'b10000, 1'b0);

        // Wrap: write pointer at 1, read pointer at 31.
        wptr_gray = 5'b00001;
        tick(3);
        check_state("wrap_lvl", 2, 1'b0, 15, 5'b10000, 1'b0);
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
        check_state("wrap_pop", 1, 1'b0, 0, 5'b00000, 1'b0);

        // Simultaneous pop and write-pointer advance 2->3.
        wptr_gray = bin2gray(5'd2);
        tick(3);
        check_state("sim_pre", 2, 1'b0, 0, 5'b00000, 1'b0);
        wptr_gray = bin2gray(5'd3);
        tick(2);
        check_state("sim_hold", 2, 1'b0, 0, 5'b00000, 1'b0);
        rd_req = 1'b1;
        tick(1);
        check_state("sim_both", 2, 1'b0, 1, 5'b00001, 1'b0);

        // Reset overrides a concurrent pop.
        rst       = 1'b1;
        wptr_gray = 5'b00000;
        tick(1);
        check_state("rst_pop", 0, 1'b1, 0, 5'b00000, 1'b0);
        rst    = 1'b0;
        rd_req = 1'b0;
        tick(2);
        check_state("rst_after", 0, 1'b1, 0, 5'b00000, 1'b0);

        // Gray-to-binary decode for every code, read pointer at 0.
        for (int v = 0; v < 32; v++) begin
            wptr_gray = bin2gray(5'(v));
            tick(3);
            for (int s = 0; s < 3; s++)
                check($sformatf("g2b.v%0d.s%0d", v, s), 32'(level[s]), 32'(v));
        end
        rst       = 1'b1;
        wptr_gray = 5'b00000;
        tick(1);
        rst = 1'b0;
        tick(2);
        check_state("rst_g2b", 0, 1'b1, 0, 5'b00000, 1'b0);

        // Overflow: binary 17 with read pointer at 0, sticky until reset.
        wptr_gray = 5'b11001;
        tick(3);
        check_state("ovf_seen", 17, 1'b0, 0, 5'b00000, 1'b0);
        tick(1);
        check_state("ovf_set", 17, 1'b0, 0, 5'b00000, 1'b1);
        wptr_gray = 5'b00000;
        tick(3);
        check_state("ovf_sticky", 0, 1'b1, 0, 5'b00000, 1'b1);
        tick(2);
        check_state("ovf_sticky2", 0, 1'b1, 0, 5'b00000, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_state("ovf_clr", 0, 1'b1, 0, 5'b00000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
